// File: rtl/ex_mdu_seq_pkg.sv
// ----------------------------------------------------------------------------
// ex_mdu_seq_pkg
// Shared definitions for the sequential multiply/divide unit:
//   - MDU_OP_W and the operation codes (MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU)
//   - FSM state encodings (MDU_IDLE, MDU_CALC, MDU_DONE)
//   - default operand width and destination register index width
//   - op_is_div(): true for the two divide-family operations
// No ports (package).
// ----------------------------------------------------------------------------
package ex_mdu_seq_pkg;

   localparam int MDU_OP_W          = 2;
   localparam int MDU_WORD_W_DEF    = 32;
   localparam int MDU_REG_IDX_W_DEF = 5;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_MUL   = 2'b00,
      MDU_MULHU = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_REMU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_CALC = 2'b01,
      MDU_DONE = 2'b10
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return (op == MDU_DIVU) || (op == MDU_REMU);
   endfunction

endpackage

// File: rtl/ex_mdu_seq_step.sv
// ----------------------------------------------------------------------------
// mdu_step
// One radix-2 iteration of the sequential MDU, purely combinational.
//   Multiply: {hi,lo} holds {partial product, remaining multiplier bits};
//             conditionally add operand (multiplicand) to hi, then shift the
//             pair right by one.
//   Divide  : {hi,lo} holds {partial remainder, remaining dividend bits};
//             shift left by one, trial-subtract operand (divisor) and shift
//             the quotient bit into lo (restoring division).
// Configuration: the divide path and the is_div port exist only when
// MDU_DIV_EN is defined.
// Ports:
//   is_div   in  1       selects the divide iteration (MDU_DIV_EN only)
//   hi, lo   in  WORD_W  current accumulator halves
//   operand  in  WORD_W  multiplicand or divisor
//   hi_nxt, lo_nxt out WORD_W  accumulator after this iteration
// ----------------------------------------------------------------------------
module mdu_step #(
   parameter int WORD_W = 32
) (
`ifdef MDU_DIV_EN
   input  logic              is_div,
`endif
   input  logic [WORD_W-1:0] hi,
   input  logic [WORD_W-1:0] lo,
   input  logic [WORD_W-1:0] operand,
   output logic [WORD_W-1:0] hi_nxt,
   output logic [WORD_W-1:0] lo_nxt
);

   logic [WORD_W:0]   addend_s;
   logic [WORD_W:0]   sum_s;
   logic [WORD_W-1:0] mul_hi_s;
   logic [WORD_W-1:0] mul_lo_s;

   // Shift-add step; the carry out of the add becomes the new top bit of hi
   always_comb begin
      if (lo[0]) begin
         addend_s = {1'b0, operand};
      end else begin
         addend_s = {(WORD_W+1){1'b0}};
      end
      sum_s    = {1'b0, hi} + addend_s;
      mul_hi_s = sum_s[WORD_W:1];
      mul_lo_s = {sum_s[0], lo[WORD_W-1:1]};
   end

`ifdef MDU_DIV_EN
   logic [WORD_W:0]   shifted_s;
   logic [WORD_W:0]   diff_s;
   logic [WORD_W-1:0] div_hi_s;
   logic [WORD_W-1:0] div_lo_s;

   // Restoring step; bit WORD_W of the difference is the borrow, since the
   // shifted remainder is always below twice the divisor
   always_comb begin
      shifted_s = {hi, lo[WORD_W-1]};
      diff_s    = shifted_s - {1'b0, operand};
      if (!diff_s[WORD_W]) begin
         div_hi_s = diff_s[WORD_W-1:0];
         div_lo_s = {lo[WORD_W-2:0], 1'b1};
      end else begin
         div_hi_s = shifted_s[WORD_W-1:0];
         div_lo_s = {lo[WORD_W-2:0], 1'b0};
      end
   end

   // Pick the iteration matching the operation in flight
   always_comb begin
      if (is_div) begin
         hi_nxt = div_hi_s;
         lo_nxt = div_lo_s;
      end else begin
         hi_nxt = mul_hi_s;
         lo_nxt = mul_lo_s;
      end
   end
`else
   // Multiply is the only iteration available
   always_comb begin
      hi_nxt = mul_hi_s;
      lo_nxt = mul_lo_s;
   end
`endif

endmodule

// File: rtl/ex_mdu_seq.sv
// ----------------------------------------------------------------------------
// ex_mdu_seq
// Sequential multiply/divide unit for the EX stage. A request accepted in
// IDLE spends exactly WORD_W cycles in CALC (one mdu_step iteration each)
// and then presents a one-cycle o_done pulse in DONE. Divide by zero, and
// any divide when division is compiled out, go straight from IDLE to DONE.
// Configuration: define MDU_DIV_EN to build the DIVU/REMU datapath; without
// it DIVU/REMU complete in one cycle with a zero result.
// Ports:
//   clk         in  1          clock, rising edge
//   clr_n       in  1          asynchronous active-low reset
//   i_start     in  1          request valid (honoured only in IDLE)
//   i_op        in  2          00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   i_opa/i_opb in  WORD_W     unsigned operands
//   i_dest_reg  in  REG_IDX_W  writeback register index
//   i_flush     in  1          abandon any operation, back to IDLE
//   o_busy      out 1          high while in CALC
//   o_done      out 1          one-cycle result-valid pulse
//   o_result    out WORD_W     result, zero when o_done=0
//   o_dest_reg  out REG_IDX_W  captured index, zero when o_done=0
// ----------------------------------------------------------------------------
module ex_mdu_seq
   import ex_mdu_seq_pkg::*;
#(
   parameter int WORD_W    = MDU_WORD_W_DEF,
   parameter int REG_IDX_W = MDU_REG_IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 i_start,
   input  logic [1:0]           i_op,
   input  logic [WORD_W-1:0]    i_opa,
   input  logic [WORD_W-1:0]    i_opb,
   input  logic [REG_IDX_W-1:0] i_dest_reg,
   input  logic                 i_flush,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [WORD_W-1:0]    o_result,
   output logic [REG_IDX_W-1:0] o_dest_reg
);

   localparam int             CNT_W    = $clog2(WORD_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdu_state_e           state_r;
   mdu_op_e              op_r;
   logic [WORD_W-1:0]    operand_r;
   logic [WORD_W-1:0]    hi_r;
   logic [WORD_W-1:0]    lo_r;
   logic [REG_IDX_W-1:0] dest_r;
   logic [CNT_W-1:0]     cnt_r;

   mdu_op_e              req_op_s;
   logic                 req_div_s;
   logic                 req_short_s;
   logic [WORD_W-1:0]    short_res_s;
   logic [WORD_W-1:0]    hi_nxt_s;
   logic [WORD_W-1:0]    lo_nxt_s;
   logic [WORD_W-1:0]    calc_res_s;

   mdu_step #(
      .WORD_W (WORD_W)
   ) u_step (
`ifdef MDU_DIV_EN
      .is_div  (op_is_div(op_r)),
`endif
      .hi      (hi_r),
      .lo      (lo_r),
      .operand (operand_r),
      .hi_nxt  (hi_nxt_s),
      .lo_nxt  (lo_nxt_s)
   );

   // Request decode: which ops bypass CALC and what they return
   always_comb begin
      req_op_s  = mdu_op_e'(i_op);
      req_div_s = op_is_div(req_op_s);
`ifdef MDU_DIV_EN
      req_short_s = req_div_s && (i_opb == {WORD_W{1'b0}});
      if (req_op_s == MDU_DIVU) begin
         short_res_s = {WORD_W{1'b1}};
      end else begin
         short_res_s = i_opa;
      end
`else
      req_short_s = req_div_s;
      short_res_s = {WORD_W{1'b0}};
`endif
   end

   // Result selection from the final iteration's outputs
   always_comb begin
      case (op_r)
         MDU_MUL:   calc_res_s = lo_nxt_s;
         MDU_MULHU: calc_res_s = hi_nxt_s;
         MDU_DIVU:  calc_res_s = lo_nxt_s;
         MDU_REMU:  calc_res_s = hi_nxt_s;
         default:   calc_res_s = {WORD_W{1'b0}};
      endcase
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r    <= MDU_IDLE;
         op_r       <= MDU_MUL;
         operand_r  <= {WORD_W{1'b0}};
         hi_r       <= {WORD_W{1'b0}};
         lo_r       <= {WORD_W{1'b0}};
         dest_r     <= {REG_IDX_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_result   <= {WORD_W{1'b0}};
         o_dest_reg <= {REG_IDX_W{1'b0}};
      end else if (i_flush) begin
         // Flush wins over everything, including a start in IDLE
         state_r    <= MDU_IDLE;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_result   <= {WORD_W{1'b0}};
         o_dest_reg <= {REG_IDX_W{1'b0}};
      end else begin
         case (state_r)
            MDU_IDLE: begin
               if (i_start) begin
                  op_r   <= req_op_s;
                  dest_r <= i_dest_reg;
                  hi_r   <= {WORD_W{1'b0}};
                  cnt_r  <= {CNT_W{1'b0}};
                  // Multiply shifts the multiplier out of lo; divide shifts
                  // the dividend out of lo and builds the quotient behind it
                  operand_r <= req_div_s ? i_opb : i_opa;
                  lo_r      <= req_div_s ? i_opa : i_opb;
                  if (req_short_s) begin
                     state_r    <= MDU_DONE;
                     o_done     <= 1'b1;
                     o_result   <= short_res_s;
                     o_dest_reg <= i_dest_reg;
                  end else begin
                     state_r <= MDU_CALC;
                     o_busy  <= 1'b1;
                  end
               end
            end
            MDU_CALC: begin
               hi_r  <= hi_nxt_s;
               lo_r  <= lo_nxt_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  state_r    <= MDU_DONE;
                  o_busy     <= 1'b0;
                  o_done     <= 1'b1;
                  o_result   <= calc_res_s;
                  o_dest_reg <= dest_r;
               end
            end
            MDU_DONE: begin
               state_r    <= MDU_IDLE;
               o_done     <= 1'b0;
               o_result   <= {WORD_W{1'b0}};
               o_dest_reg <= {REG_IDX_W{1'b0}};
            end
            default: begin
               state_r    <= MDU_IDLE;
               o_busy     <= 1'b0;
               o_done     <= 1'b0;
               o_result   <= {WORD_W{1'b0}};
               o_dest_reg <= {REG_IDX_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu_seq.sv
// ----------------------------------------------------------------------------
// tb_ex_mdu_seq
// Scoreboard bench for ex_mdu_seq: each accepted request pushes its expected
// result, destination and latency; a monitor on the falling edge pops and
// compares on every o_done and checks the outputs are zero otherwise.
// Latency is counted in clock edges from the start-sampling edge's cycle:
// full-length operations complete 33 cycles after start, the short path
// completes in the cycle right after the start cycle.
// ----------------------------------------------------------------------------
module tb_ex_mdu_seq;

   localparam int W  = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          i_start;
   logic [1:0]    i_op;
   logic [W-1:0]  i_opa;
   logic [W-1:0]  i_opb;
   logic [RW-1:0] i_dest_reg;
   logic          i_flush;
   logic          o_busy;
   logic          o_done;
   logic [W-1:0]  o_result;
   logic [RW-1:0] o_dest_reg;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0]  res;
      logic [RW-1:0] dest;
      int            start;
      int            lat;
   } exp_t;

   exp_t sb_q[$];

   localparam int LAT_LONG  = 33;
   localparam int LAT_SHORT = 1;

`ifdef MDU_DIV_EN
   localparam logic [W-1:0] EXP_DIVU   = 32'd14;
   localparam logic [W-1:0] EXP_REMU   = 32'd2;
   localparam int           LAT_DIV    = LAT_LONG;
   localparam logic [W-1:0] EXP_DIVU_Z = 32'hFFFF_FFFF;
   localparam logic [W-1:0] EXP_REMU_Z = 32'd5;
`else
   localparam logic [W-1:0] EXP_DIVU   = 32'd0;
   localparam logic [W-1:0] EXP_REMU   = 32'd0;
   localparam int           LAT_DIV    = LAT_SHORT;
   localparam logic [W-1:0] EXP_DIVU_Z = 32'd0;
   localparam logic [W-1:0] EXP_REMU_Z = 32'd0;
`endif

   ex_mdu_seq #(.WORD_W(W), .REG_IDX_W(RW)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .i_start    (i_start),
      .i_op       (i_op),
      .i_opa      (i_opa),
      .i_opb      (i_opb),
      .i_dest_reg (i_dest_reg),
      .i_flush    (i_flush),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_result   (o_result),
      .o_dest_reg (o_dest_reg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pop one expectation per done pulse, zero outputs otherwise
   always @(negedge clk) begin
      exp_t e;
      if (o_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=result %0h dest %0d required=no pulse (cycle %0d)",
                     o_result, o_dest_reg, cyc);
         end else begin
            e = sb_q.pop_front();
            check("result", 64'(o_result), 64'(e.res));
            check("dest_reg", 64'(o_dest_reg), 64'(e.dest));
            check("latency", 64'(cyc - e.start), 64'(e.lat));
         end
      end else begin
         check("idle_outputs_zero", 64'({o_result, o_dest_reg}), 64'd0);
      end
   end

   task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] d);
      i_start    = 1'b1;
      i_op       = op;
      i_opa      = a;
      i_opb      = b;
      i_dest_reg = d;
   endtask

   // Issue one request at a falling edge and register its expectation
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] d, input logic [W-1:0] res, input int lat);
      @(negedge clk);
      drive(op, a, b, d);
      sb_q.push_back('{res, d, cyc, lat});
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=still running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      clr_n = 1'b0;
      i_start = 1'b0; i_op = 2'b00; i_opa = 32'd0; i_opb = 32'd0;
      i_dest_reg = 5'd0; i_flush = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(o_busy), 64'd0);
      check("reset_done", 64'(o_done), 64'd0);
      check("reset_result", 64'(o_result), 64'd0);
      check("reset_dest", 64'(o_dest_reg), 64'd0);
      clr_n = 1'b1;

      // Main function under several operand patterns
      issue(2'b00, 32'd7, 32'd6, 5'd5, 32'd42, LAT_LONG);                   drain(60);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, LAT_LONG); drain(60);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, LAT_LONG); drain(60);
      issue(2'b10, 32'd100, 32'd7, 5'd3, EXP_DIVU, LAT_DIV);                drain(60);
      issue(2'b11, 32'd100, 32'd7, 5'd4, EXP_REMU, LAT_DIV);                drain(60);
      issue(2'b10, 32'd5, 32'd0, 5'd6, EXP_DIVU_Z, LAT_SHORT);              drain(60);
      issue(2'b11, 32'd5, 32'd0, 5'd7, EXP_REMU_Z, LAT_SHORT);              drain(60);

      // Flush on CALC cycle 10: back to IDLE, no done for this operation
      @(negedge clk);
      drive(2'b00, 32'd3, 32'd3, 5'd8);
      @(negedge clk);
      i_start = 1'b0;
      check("busy_in_calc", 64'(o_busy), 64'd1);
      repeat (8) @(negedge clk);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      check("busy_after_flush", 64'(o_busy), 64'd0);
      repeat (40) @(negedge clk);
      issue(2'b00, 32'd3, 32'd5, 5'd9, 32'd15, LAT_LONG);                   drain(60);

      // Second start during CALC is ignored
      issue(2'b00, 32'd9, 32'd9, 5'd10, 32'd81, LAT_LONG);
      repeat (5) @(negedge clk);
      drive(2'b00, 32'd2, 32'd2, 5'd11);
      @(negedge clk);
      i_start = 1'b0;
      drain(60);
      repeat (40) @(negedge clk);

      // Flush together with start in IDLE drops the start
      @(negedge clk);
      drive(2'b00, 32'd5, 32'd5, 5'd12);
      i_flush = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_flush = 1'b0;
      check("busy_flush_start", 64'(o_busy), 64'd0);
      repeat (40) @(negedge clk);

      // Asynchronous reset mid-CALC, between edges
      @(negedge clk);
      drive(2'b00, 32'd6, 32'd7, 5'd13);
      @(negedge clk);
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      clr_n = 1'b0;
      #1;
      check("areset_busy", 64'(o_busy), 64'd0);
      check("areset_done", 64'(o_done), 64'd0);
      check("areset_result", 64'(o_result), 64'd0);
      check("areset_dest", 64'(o_dest_reg), 64'd0);
      @(negedge clk);
      clr_n = 1'b1;
      repeat (40) @(negedge clk);

      // Start presented together with reset release is taken on the first edge
      clr_n = 1'b0;
      @(negedge clk);
      #2;
      clr_n = 1'b1;
      drive(2'b00, 32'd4, 32'd4, 5'd14);
      sb_q.push_back('{32'd16, 5'd14, cyc, LAT_LONG});
      @(negedge clk);
      i_start = 1'b0;
      drain(60);
      repeat (10) @(negedge clk);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
